// File: rtl/prog_loader.sv
// Boot-time program loader: assembles big-endian words from a byte stream,
// fills instruction memory up to a HALT word, then a counted data section.
module prog_loader #(
  parameter int          IMEM_DEPTH = 200,
  parameter int          DMEM_DEPTH = 10000,
  parameter logic [31:0] HALT_WORD  = 32'hffffffff,
  parameter int          IA_W       = 8,
  parameter int          DA_W       = 14
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            imem_we,
  output logic [IA_W-1:0] imem_addr,
  output logic [31:0]     imem_wdata,
  output logic            dmem_we,
  output logic [DA_W-1:0] dmem_addr,
  output logic [31:0]     dmem_wdata,
  output logic            cpu_run,
  output logic            err,
  output logic [IA_W-1:0] inst_count
);

  typedef enum logic [2:0] {S_INST, S_DCNT, S_DATA, S_DONE, S_ERR} state_t;

  state_t          r_state;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_word;
  logic [IA_W-1:0] r_iptr;
  logic [DA_W-1:0] r_dptr;
  logic [DA_W-1:0] r_remain;

  logic        w_accept;
  logic        w_word_done;
  logic [31:0] w_word;

  assign w_accept    = in_valid & in_ready;
  assign w_word_done = w_accept && (r_byte_cnt == 2'd3);
  assign w_word      = {r_word, in_data};

  // NOTE: all state here is non-blocking; the target memories live outside,
  // so nothing large needs (or gets) a reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_INST;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_iptr     <= '0;
      r_dptr     <= '0;
      r_remain   <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cpu_run    <= 1'b0;
      err        <= 1'b0;
      inst_count <= '0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      case (r_state)
        S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_INST;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_iptr     <= '0;
            r_dptr     <= '0;
            r_remain   <= '0;
            in_ready   <= 1'b1;
            imem_addr  <= '0;
            dmem_addr  <= '0;
            cpu_run    <= 1'b0;
            err        <= 1'b0;
            inst_count <= '0;
          end else begin
            in_ready <= 1'b0;
            cpu_run  <= (r_state == S_DONE);
            err      <= (r_state == S_ERR);
          end
        end
        default: begin
          // Terminal transitions below override this so no byte slips into DONE/ERR.
          in_ready <= 1'b1;
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= {r_word[15:0], in_data};
          end
          if (w_word_done) begin
            case (r_state)
              S_INST: begin
                imem_we    <= 1'b1;
                imem_addr  <= r_iptr;
                imem_wdata <= w_word;
                r_iptr     <= r_iptr + 1'b1;
                inst_count <= inst_count + 1'b1;
                if (w_word == HALT_WORD) begin
                  r_state <= S_DCNT;
                end else if (r_iptr == IA_W'(IMEM_DEPTH - 1)) begin
                  r_state  <= S_ERR;
                  err      <= 1'b1;
                  in_ready <= 1'b0;
                end
              end
              S_DCNT: begin
                if (w_word == 32'd0) begin
                  r_state  <= S_DONE;
                  in_ready <= 1'b0;
                end else if (w_word > 32'(DMEM_DEPTH)) begin
                  r_state  <= S_ERR;
                  err      <= 1'b1;
                  in_ready <= 1'b0;
                end else begin
                  r_remain  <= w_word[DA_W-1:0];
                  r_dptr    <= '0;
                  dmem_addr <= '0;
                  r_state   <= S_DATA;
                end
              end
              S_DATA: begin
                dmem_we    <= 1'b1;
                dmem_addr  <= r_dptr;
                dmem_wdata <= w_word;
                r_dptr     <= r_dptr + 1'b1;
                r_remain   <= r_remain - 1'b1;
                if (r_remain == DA_W'(1)) begin
                  r_state  <= S_DONE;
                  in_ready <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table-driven word loads plus hand-written
// sequences for overflow, count errors, restart and mid-load reset.
module tb_prog_loader;

  localparam logic [31:0] HALT = 32'hffffffff;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        cpu_run;
  logic        err;
  logic [7:0]  inst_count;

  prog_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .cpu_run    (cpu_run),
    .err        (err),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        exp_i;
    logic        exp_d;
    int          addr;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs [16];
  int   n_vecs;

  int n_pass  = 0;
  int n_total = 0;

  // Memory models and strobe bookkeeping fed from the write ports.
  logic [31:0] imem_m [0:255];
  logic [31:0] dmem_m [0:16383];
  int   n_iwr = 0, n_dwr = 0, n_dbl = 0;
  logic prev_i = 1'b0, prev_d = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      imem_m[imem_addr] = imem_wdata;
      n_iwr++;
    end
    if (dmem_we) begin
      dmem_m[dmem_addr] = dmem_wdata;
      n_dwr++;
    end
    if ((imem_we && prev_i) || (dmem_we && prev_d)) n_dbl++;
    prev_i = imem_we;
    prev_d = dmem_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      imem_m[i] = '0;
      dmem_m[i] = '0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    int gap;
    for (int b = 0; b < 4; b++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      send_byte(w[31-8*b -: 8], gap);
    end
  endtask

  // Sampled half a cycle after the 4th byte's handshake edge.
  task automatic check_strobe(input logic ei, input logic ed, input int addr,
                              input logic [31:0] data, input logic rdy);
    @(negedge clk);
    check("imem_we", 32'(imem_we), 32'(ei));
    check("dmem_we", 32'(dmem_we), 32'(ed));
    if (ei) begin
      check("imem_addr", 32'(imem_addr), 32'(addr));
      check("imem_wdata", imem_wdata, data);
    end
    if (ed) begin
      check("dmem_addr", 32'(dmem_addr), 32'(addr));
      check("dmem_wdata", dmem_wdata, data);
    end
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("cpu_run_early", 32'(cpu_run), 32'd0);
  endtask

  task automatic run_table(input int gap_max);
    for (int i = 0; i < n_vecs; i++) begin
      send_word(vecs[i].word, gap_max);
      check_strobe(vecs[i].exp_i, vecs[i].exp_d, vecs[i].addr, vecs[i].word, vecs[i].exp_rdy);
    end
    @(negedge clk);
    check("cpu_run_rise", 32'(cpu_run), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
    #1;
    for (int i = 0; i < n_vecs; i++) begin
      if (vecs[i].exp_i) check("imem_model", imem_m[vecs[i].addr], vecs[i].word);
      if (vecs[i].exp_d) check("dmem_model", dmem_m[vecs[i].addr], vecs[i].word);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_tbl1();
    vecs[0] = '{32'h20010000, 1'b1, 1'b0, 0, 1'b1};
    vecs[1] = '{32'h08000000, 1'b1, 1'b0, 1, 1'b1};
    vecs[2] = '{HALT,         1'b1, 1'b0, 2, 1'b1};
    vecs[3] = '{32'd2,        1'b0, 1'b0, 0, 1'b1};
    vecs[4] = '{32'h3f800000, 1'b0, 1'b1, 0, 1'b1};
    vecs[5] = '{32'h40800000, 1'b0, 1'b1, 1, 1'b0};
    n_vecs = 6;
  endtask

  task automatic load_tbl2();
    vecs[0] = '{32'h00000013, 1'b1, 1'b0, 0, 1'b1};
    vecs[1] = '{32'h00100093, 1'b1, 1'b0, 1, 1'b1};
    vecs[2] = '{32'hdeadbeef, 1'b1, 1'b0, 2, 1'b1};
    vecs[3] = '{32'h12345678, 1'b1, 1'b0, 3, 1'b1};
    vecs[4] = '{HALT,         1'b1, 1'b0, 4, 1'b1};
    vecs[5] = '{32'd4,        1'b0, 1'b0, 0, 1'b1};
    vecs[6] = '{32'h11111111, 1'b0, 1'b1, 0, 1'b1};
    vecs[7] = '{32'h80000000, 1'b0, 1'b1, 1, 1'b1};
    vecs[8] = '{32'h0000ffff, 1'b0, 1'b1, 2, 1'b1};
    vecs[9] = '{32'hcafef00d, 1'b0, 1'b1, 3, 1'b0};
    n_vecs = 10;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_cpu_run"},    32'(cpu_run),    32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_imem_we"},    32'(imem_we),    32'd0);
    check({tag, "_dmem_we"},    32'(dmem_we),    32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_dmem_addr"},  32'(dmem_addr),  32'd0);
    check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    check({tag, "_dmem_wdata"}, dmem_wdata,      32'd0);
    check({tag, "_inst_count"}, 32'(inst_count), 32'd0);
  endtask

  initial begin
    int snap;
    logic [31:0] w;
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    clear_models();

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Basic image: 3 instructions, 2 data words
    load_tbl1();
    run_table(0);
    check("inst_count_tbl1", 32'(inst_count), 32'd3);
    @(negedge clk);
    check("cpu_run_hold", 32'(cpu_run), 32'd1);

    // HALT then N=0
    start_pulse();
    check("start_cpu_run", 32'(cpu_run), 32'd0);
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_inst_count", 32'(inst_count), 32'd0);
    snap = n_dwr;
    vecs[0] = '{HALT,  1'b1, 1'b0, 0, 1'b1};
    vecs[1] = '{32'd0, 1'b0, 1'b0, 0, 1'b0};
    n_vecs = 2;
    run_table(0);
    check("n0_inst_count", 32'(inst_count), 32'd1);
    check("n0_no_dmem", 32'(n_dwr - snap), 32'd0);

    // 200 non-terminator words overflow imem
    start_pulse();
    for (int i = 0; i < 200; i++) begin
      w = 32'h10000000 + 32'(i);
      send_word(w, 0);
      check_strobe(1'b1, 1'b0, i, w, i < 199);
    end
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_inst_count", 32'(inst_count), 32'd200);
    @(negedge clk);
    check("ovf_err_hold", 32'(err), 32'd1);
    check("ovf_cpu_run", 32'(cpu_run), 32'd0);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    start_pulse();
    check("ovf_restart_err", 32'(err), 32'd0);
    check("ovf_restart_rdy", 32'(in_ready), 32'd1);
    send_word(32'h11223344, 0);
    check_strobe(1'b1, 1'b0, 0, 32'h11223344, 1'b1);
    check("restart_inst_count", 32'(inst_count), 32'd1);

    // N = DMEM_DEPTH+1 is an error with no data write
    send_word(HALT, 0);
    check_strobe(1'b1, 1'b0, 1, HALT, 1'b1);
    snap = n_dwr;
    send_word(32'd10001, 0);
    check_strobe(1'b0, 1'b0, 0, 32'd10001, 1'b0);
    check("ncnt_err", 32'(err), 32'd1);
    #1;
    check("ncnt_no_dmem", 32'(n_dwr - snap), 32'd0);

    // N = DMEM_DEPTH fills data memory completely; a start mid-load is ignored
    start_pulse();
    send_word(HALT, 0);
    check_strobe(1'b1, 1'b0, 0, HALT, 1'b1);
    send_word(32'd10000, 0);
    check_strobe(1'b0, 1'b0, 0, 32'd10000, 1'b1);
    start_pulse();
    snap = n_dwr;
    for (int i = 0; i < 9999; i++) send_word(32'(i) ^ 32'h5a5a0000, 0);
    send_word(32'd9999 ^ 32'h5a5a0000, 0);
    check_strobe(1'b0, 1'b1, 9999, 32'd9999 ^ 32'h5a5a0000, 1'b0);
    @(negedge clk);
    check("full_cpu_run", 32'(cpu_run), 32'd1);
    #1;
    check("full_dmem_writes", 32'(n_dwr - snap), 32'd10000);
    check("full_dmem0", dmem_m[0], 32'h5a5a0000);
    check("full_dmem5000", dmem_m[5000], 32'd5000 ^ 32'h5a5a0000);

    // 5-inst/4-data image, gap-free then randomly gapped
    load_tbl2();
    start_pulse();
    clear_models();
    run_table(0);
    start_pulse();
    clear_models();
    run_table(5);
    check("gap_inst_count", 32'(inst_count), 32'd5);

    // Reset after 2 bytes of the 2nd data word, then full reload
    start_pulse();
    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].word, 0);
      check_strobe(vecs[i].exp_i, vecs[i].exp_d, vecs[i].addr, vecs[i].word, vecs[i].exp_rdy);
    end
    send_byte(vecs[7].word[31:24], 0);
    send_byte(vecs[7].word[23:16], 0);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rstn = 1'b1;
    clear_models();
    run_table(0);
    check("reload_inst_count", 32'(inst_count), 32'd5);

    check("no_back_to_back_strobe", 32'(n_dbl), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader for the core.
- Accepts a byte stream (from the UART receiver), assembles big-endian 32-bit words, and writes them into instruction memory and then data memory.
- Releases the CPU when the image is complete.
- Replaces hard-coded program/data images: the memories are filled at run time, and the CPU is held idle until loading finishes.

Parameters:
- IMEM_DEPTH, 200, instruction memory words.
- DMEM_DEPTH, 10000, data memory words.
- HALT_WORD, 32'hffffffff, instruction-section terminator.
- IA_W, 8, imem address width (must satisfy 2**IA_W >= IMEM_DEPTH).
- DA_W, 14, dmem address width (must satisfy 2**DA_W >= DMEM_DEPTH).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; restarts loading from DONE or ERR
- in_data  in  8  stream byte
- in_valid  in  1  stream byte valid
- in_ready  out  1  loader accepts byte
- imem_we  out  1  instruction write strobe
- imem_addr  out  IA_W  instruction write address
- imem_wdata  out  32  instruction write data
- dmem_we  out  1  data write strobe
- dmem_addr  out  DA_W  data write address
- dmem_wdata  out  32  data write data
- cpu_run  out  1  high = CPU may execute
- err  out  1  sticky load error
- inst_count  out  IA_W  instructions written, including terminator

Behaviour:
- Clock and reset:
  - Single clock domain. rstn low asynchronously forces state INST and clears byte counter, addresses, counts and word register.
  - Reset values of all outputs: in_ready=0 during reset, cpu_run=0, err=0, all strobes, addresses and data 0.
- Byte handshake:
  - A byte is accepted on a rising edge with in_valid&in_ready.
  - The first byte of a word is bits [31:24], the fourth is [7:0].
  - A 2-bit byte counter wraps 3->0 on word completion.
- in_ready:
  - Registered. High in INST, DCNT and DATA; low in DONE and ERR.
  - Never dropped for write strobes; writes do not stall the stream.
- Write strobe timing: a strobe pulses for exactly one cycle, the cycle after the 4th byte handshake, with address and data stable that cycle. Back-to-back words produce strobes at most every 4 cycles.
- States:
  - INST: each completed word is written to imem at address imem_addr, then the address increments.
    - Word == HALT_WORD: written, then go to DCNT.
    - Word != HALT_WORD and it was the write to address IMEM_DEPTH-1: go to ERR.
  - DCNT: the completed word is N, the data word count; no write.
    - N == 0: go to DONE.
    - N > DMEM_DEPTH: go to ERR.
    - Otherwise: load the remaining count N, set dmem_addr=0, go to DATA.
  - DATA: each completed word is written to dmem at dmem_addr, then the address increments and the remaining count decrements. When the last word's strobe issues, go to DONE.
  - DONE: cpu_run=1 from the cycle after the final strobe (or after the count word if N=0). Incoming bytes are ignored (in_ready=0).
  - ERR: err=1 and cpu_run=0, both held until start or reset.
- start:
  - Sampled only in DONE or ERR.
  - Takes effect next cycle: cpu_run=0, err=0, addresses, counts and byte counter cleared, state INST.
  - Ignored in INST, DCNT and DATA.
- inst_count equals the number of imem writes since last reset or start.
- A partial word pending when start is applied is discarded.
- Reset mid-load aborts immediately. Memories are not cleared.

Test Plan:
- Load 3 words 0x20010000, 0x08000000, HALT_WORD, then N=2, data 0x3f800000, 0x40800000:
  - imem[0..2] written with those values, strobes 1 cycle after each 4th byte.
  - dmem[0]=0x3f800000, dmem[1]=0x40800000.
  - cpu_run rises the cycle after the dmem[1] strobe; inst_count=3.
- HALT_WORD then N=0: one imem write at address 0, no dmem writes, cpu_run=1 after the count word, in_ready=0.
- 200 non-terminator words: 200 imem writes, err=1 after the last, cpu_run stays 0, in_ready=0. Then start pulse: err=0, in_ready=1, next word written to imem_addr=0.
- N=10001: err=1 and no dmem write. With N=10000, full load reaches DONE with final dmem_addr=9999.
- Randomly gapped in_valid (0-5 idle cycles between bytes) over a 5-inst/4-data image: contents identical to the gap-free case, each strobe exactly one cycle.
- Assert rstn low after 2 bytes of the 2nd data word:
  - All outputs return to reset values asynchronously.
  - After release, a full reload from INST succeeds.
